// File: rtl/lane_issue_arbiter_if.sv
// rtl/lane_issue_arbiter_if.sv - producer/consumer bundle for the two-lane issue arbiter
//
// Groups every non-clock/reset signal of lane_issue_arbiter.
//   Producer lanes : in_address_x, in_id_x, in_valid_x  -> arbiter
//                    out_stall_x                       <- arbiter
//   Flush          : flush_x, flush_id_x               -> arbiter
//   Downstream     : out_address, out_id, out_lane, out_valid <- arbiter
//                    in_stall                                -> arbiter
//   Statistics     : drop_count                              <- arbiter
// The slave modport is the arbiter's view, the master modport the environment's.

interface lane_issue_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int ID_W   = 8
) ();
    logic [ADDR_W-1:0] in_address_1;
    logic [ADDR_W-1:0] in_address_2;
    logic [ID_W-1:0]   in_id_1;
    logic [ID_W-1:0]   in_id_2;
    logic              in_valid_1;
    logic              in_valid_2;
    logic              out_stall_1;
    logic              out_stall_2;
    logic              flush_1;
    logic              flush_2;
    logic [ID_W-1:0]   flush_id_1;
    logic [ID_W-1:0]   flush_id_2;
    logic [ADDR_W-1:0] out_address;
    logic [ID_W-1:0]   out_id;
    logic              out_lane;
    logic              out_valid;
    logic              in_stall;
    logic [7:0]        drop_count;

    modport slave (
        input  in_address_1, in_address_2, in_id_1, in_id_2, in_valid_1, in_valid_2,
        input  flush_1, flush_2, flush_id_1, flush_id_2, in_stall,
        output out_stall_1, out_stall_2, out_address, out_id, out_lane, out_valid,
        output drop_count
    );

    modport master (
        output in_address_1, in_address_2, in_id_1, in_id_2, in_valid_1, in_valid_2,
        output flush_1, flush_2, flush_id_1, flush_id_2, in_stall,
        input  out_stall_1, out_stall_2, out_address, out_id, out_lane, out_valid,
        input  drop_count
    );
endinterface

// File: rtl/lane_issue_arbiter.sv
// rtl/lane_issue_arbiter.sv - two-lane buffered round-robin issue arbiter with ID flush
//
// Each producer lane owns a DEPTH-entry FIFO of {address, id, live}. Live heads of the
// two FIFOs compete round-robin for a single output register that feeds the shared
// downstream port. A flush pulse on a lane clears the live bit of every buffered entry
// (and of a same-cycle incoming entry) whose ID matches; dead heads are discarded
// without ever reaching the output. A matching entry held in the output register under
// downstream stall is recalled as well. Every kill is added to a saturating drop count.
//
// Ports:
//   clk    - clock
//   reset  - asynchronous, active-high reset
//   bus    - lane_issue_arbiter_if.slave (lane inputs, stalls, flushes, output port,
//            downstream stall, drop_count)

module lane_issue_arbiter #(
    parameter int ADDR_W = 32,
    parameter int ID_W   = 8,
    parameter int DEPTH  = 4
) (
    input logic                 clk,
    input logic                 reset,
    lane_issue_arbiter_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Lane-indexed views of the bus so both lanes share one description.
    logic [ADDR_W-1:0] in_addr  [2];
    logic [ID_W-1:0]   in_id    [2];
    logic              in_vld   [2];
    logic              flush    [2];
    logic [ID_W-1:0]   flush_id [2];

    assign in_addr[0]  = bus.in_address_1;
    assign in_addr[1]  = bus.in_address_2;
    assign in_id[0]    = bus.in_id_1;
    assign in_id[1]    = bus.in_id_2;
    assign in_vld[0]   = bus.in_valid_1;
    assign in_vld[1]   = bus.in_valid_2;
    assign flush[0]    = bus.flush_1;
    assign flush[1]    = bus.flush_2;
    assign flush_id[0] = bus.flush_id_1;
    assign flush_id[1] = bus.flush_id_2;

    // FIFO payload (no reset needed: only slots with live=1 are ever consulted).
    logic [ADDR_W-1:0] addr_mem [2][DEPTH];
    logic [ID_W-1:0]   id_mem   [2][DEPTH];

    // FIFO control state. A slot's live bit is cleared when it is popped, so live=1
    // implies the slot is occupied and flush matching needs no occupancy mask.
    logic [DEPTH-1:0]  live_q [2];
    logic [DEPTH-1:0]  live_d [2];
    logic [PW-1:0]     rd_q   [2];
    logic [PW-1:0]     rd_d   [2];
    logic [PW-1:0]     wr_q   [2];
    logic [PW-1:0]     wr_d   [2];
    logic [CW-1:0]     cnt_q  [2];
    logic [CW-1:0]     cnt_d  [2];

    // Output register and arbitration state. last_q: 0 = lane 1, 1 = lane 2.
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [ID_W-1:0]   out_id_q, out_id_d;
    logic              out_lane_q, out_lane_d;
    logic              out_valid_q, out_valid_d;
    logic              last_q, last_d;
    logic [7:0]        drop_q, drop_d;

    // Combinational decode.
    logic              full      [2];
    logic              empty     [2];
    logic              head_live [2];
    logic              cand      [2];
    logic              push      [2];
    logic              push_live [2];
    logic              pop       [2];
    logic [DEPTH-1:0]  kill      [2];
    logic              load_ok;
    logic              grant_en;
    logic              gsel;
    logic              out_kill;
    logic [15:0]       kills;
    logic [15:0]       drop_sum;

    always_comb begin
        load_ok     = !out_valid_q || !bus.in_stall;
        kills       = '0;
        out_addr_d  = out_addr_q;
        out_id_d    = out_id_q;
        out_lane_d  = out_lane_q;
        out_valid_d = out_valid_q;
        last_d      = last_q;

        for (int l = 0; l < 2; l++) begin
            full[l]      = (cnt_q[l] == FULL_CNT);
            empty[l]     = (cnt_q[l] == '0);
            head_live[l] = live_q[l][rd_q[l]];
            for (int i = 0; i < DEPTH; i++) begin
                kill[l][i] = flush[l] && live_q[l][i] && (id_mem[l][i] == flush_id[l]);
            end
            // A head killed this cycle is not issued; it turns into a dead head and
            // is discarded on the following cycle.
            cand[l]      = !empty[l] && head_live[l] && !kill[l][rd_q[l]];
            // A full FIFO never accepts, even if its head leaves this cycle.
            push[l]      = in_vld[l] && !full[l];
            push_live[l] = !(flush[l] && (in_id[l] == flush_id[l]));
        end

        // Round-robin on a tie: the lane that did not win last; otherwise whichever
        // single lane has a candidate.
        gsel     = (cand[0] && cand[1]) ? !last_q : cand[1];
        grant_en = load_ok && (cand[0] || cand[1]);

        // Recall of a stalled output entry. Only possible while stalled with valid
        // data, which is exactly when the output register cannot load.
        out_kill = out_valid_q && bus.in_stall && flush[out_lane_q]
                   && (out_id_q == flush_id[out_lane_q]);

        for (int l = 0; l < 2; l++) begin
            // Dead-head discard and grant pop are mutually exclusive (grant needs live).
            pop[l]    = (!empty[l] && !head_live[l]) || (grant_en && (gsel == (l == 1)));
            live_d[l] = live_q[l] & ~kill[l];
            if (pop[l]) begin
                live_d[l][rd_q[l]] = 1'b0;
            end
            // Push and pop never target the same slot: pop needs count>0, push needs
            // count<DEPTH, so wr != rd whenever both happen.
            if (push[l]) begin
                live_d[l][wr_q[l]] = push_live[l];
            end
            cnt_d[l] = cnt_q[l] + CW'(push[l]) - CW'(pop[l]);
            rd_d[l]  = rd_q[l] + PW'(pop[l]);
            wr_d[l]  = wr_q[l] + PW'(push[l]);
            for (int i = 0; i < DEPTH; i++) begin
                kills = kills + 16'(kill[l][i]);
            end
            kills = kills + 16'(push[l] && !push_live[l]);
        end
        kills = kills + 16'(out_kill);

        if (load_ok) begin
            if (grant_en) begin
                out_addr_d  = addr_mem[gsel][rd_q[gsel]];
                out_id_d    = id_mem[gsel][rd_q[gsel]];
                out_lane_d  = gsel;
                out_valid_d = 1'b1;
                last_d      = gsel;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (out_kill) begin
            out_valid_d = 1'b0;
        end

        drop_sum = 16'(drop_q) + kills;
        drop_d   = (drop_sum > 16'd255) ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int l = 0; l < 2; l++) begin
                live_q[l] <= '0;
                rd_q[l]   <= '0;
                wr_q[l]   <= '0;
                cnt_q[l]  <= '0;
            end
            out_addr_q  <= '0;
            out_id_q    <= '0;
            out_lane_q  <= 1'b0;
            out_valid_q <= 1'b0;
            last_q      <= 1'b1;   // lane 2 "won last", so lane 1 wins the first tie
            drop_q      <= '0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                live_q[l] <= live_d[l];
                rd_q[l]   <= rd_d[l];
                wr_q[l]   <= wr_d[l];
                cnt_q[l]  <= cnt_d[l];
            end
            out_addr_q  <= out_addr_d;
            out_id_q    <= out_id_d;
            out_lane_q  <= out_lane_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
            drop_q      <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < 2; l++) begin
            if (push[l]) begin
                addr_mem[l][wr_q[l]] <= in_addr[l];
                id_mem[l][wr_q[l]]   <= in_id[l];
            end
        end
    end

    assign bus.out_address = out_addr_q;
    assign bus.out_id      = out_id_q;
    assign bus.out_lane    = out_lane_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_stall_1 = full[0];
    assign bus.out_stall_2 = full[1];
    assign bus.drop_count  = drop_q;

endmodule
